cpu_host_seq: RTL
=================

CPU_HOST_SEQ -- requirements
Module: cpu_host_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning CPU data operand width.
REQ-002 SHALL have parameter DEPTH, default 8, meaning program and result buffer entries (power of 2).
REQ-003 SHALL have parameter TIMEOUT, default 64, meaning max cycles to wait per cpu_rdy phase.
REQ-004 clk1  in  1  sole clock, all logic rising-edge.
REQ-005 reset1  in  1  synchronous, active-low reset.
REQ-006 prog_we  in  1  write program entry when high and state IDLE.
REQ-007 prog_addr  in  clog2(DEPTH)  program entry index.
REQ-008 prog_cmd  in  7  command word stored at prog_addr.
REQ-009 prog_opa, prog_opb  in  WIDTH each  operands stored at prog_addr.
REQ-010 prog_len  in  clog2(DEPTH)+1  entries to run (0 = none), sampled on start.
REQ-011 start  in  1  one-cycle pulse, begins run from entry 0.
REQ-012 stop_on_err  in  1  sampled on start; halt run at first CPU error.
REQ-013 cpu_rdy  in  1  CPU ready / done indication.
REQ-014 cpu_result  in  2*WIDTH  CPU result register.
REQ-015 cpu_zero, cpu_error  in  1 each  CPU flags.
REQ-016 cmd_out  out  7  command to CPU; 7'h00 = no command.
REQ-017 op_a, op_b  out  WIDTH each  operands driven to CPU data inputs.
REQ-018 busy  out  1  high from start accept until DONE.
REQ-019 done  out  1  one-cycle pulse at run end.
REQ-020 timeout  out  1  sticky; set on TIMEOUT expiry, cleared on next start.
REQ-021 res_count  out  clog2(DEPTH)+1  results captured in last run.
REQ-022 res_addr  in  clog2(DEPTH); res_data  out  2*WIDTH+2  combinational read {error, zero, result}.

Function
REQ-023 FSM states SHALL be IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, CAPTURE, DONE.
REQ-024 IDLE: start with prog_len=0 -> DONE; start with prog_len>0 -> ISSUE, pc=0, res_count=0, timeout=0.
REQ-025 start while busy SHALL be ignored; prog_we while not IDLE SHALL be ignored.
REQ-026 ISSUE: wait cpu_rdy=1; then drive cmd_out=prog_cmd[pc] for exactly one cycle -> WAIT_BUSY.
REQ-027 op_a/op_b SHALL equal prog_opa/opb[pc] from ISSUE entry through CAPTURE.
REQ-028 WAIT_BUSY: cpu_rdy=0 -> WAIT_DONE.
REQ-029 WAIT_DONE: cpu_rdy=1 -> CAPTURE.
REQ-030 CAPTURE (one cycle): write {cpu_error, cpu_zero, cpu_result} to result[pc], res_count+1.
REQ-031 After CAPTURE: pc==prog_len-1, or stop_on_err and cpu_error=1 -> DONE; else pc+1 -> ISSUE.
REQ-032 Per-phase counter SHALL clear on entering ISSUE/WAIT_BUSY/WAIT_DONE; reaching TIMEOUT in any -> timeout=1, DONE, no capture.
REQ-033 DONE: done=1 one cycle, cmd_out=0 -> IDLE.
REQ-034 cmd_out SHALL be 7'h00 in every cycle except the issue cycle.
REQ-035 res_data for addr >= res_count SHALL return stale contents (unspecified).
REQ-036 pc SHALL never wrap; prog_len>DEPTH SHALL be saturated to DEPTH.

Reset
REQ-037 reset1=0 at clock edge: state IDLE, pc=0, cmd_out=0, op_a=op_b=0, busy=0, done=0, timeout=0, res_count=0.
REQ-038 Program and result storage SHALL NOT be reset.
REQ-039 Reset mid-run SHALL abort with no done pulse.

Structure
REQ-040 State enum and NOP_CMD (7'h00) SHALL reside in shared package cpu_pkg.
REQ-041 Timeout counter SHALL be sub-module phase_timer (clear, enable, expired).

Verification
REQ-042 Load 3 entries, prog_len=3, CPU model 2-cycle busy -> three captures, res_count=3, one done pulse.
REQ-043 Entry 1 returns error=1, stop_on_err=1 -> res_count=2, done, pc stopped at 1.
REQ-044 cpu_rdy held 1 after issue for 64 cycles -> timeout=1, done, res_count=0.
REQ-045 prog_len=0 start -> done two cycles later, cmd_out never nonzero.
REQ-046 reset1=0 during WAIT_DONE -> all outputs reset values next cycle, no done.
REQ-047 start pulse while busy and prog_we while busy -> no effect on run or program.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU host sequencer.
package cpu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        CAPTURE,
        DONE
    } state_t;

    localparam logic [6:0] NOP_CMD = 7'h00;

endpackage

// File: rtl/phase_timer.sv
// Per-phase cycle counter; expired flags the TIMEOUT-th cycle spent in a phase.
module phase_timer #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && !o_expired) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = i_enable && (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/cpu_host_seq.sv
// Sequencer that replays a small program of commands into a CPU and
// captures each {error, zero, result} response into a result buffer.
module cpu_host_seq
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                       clk1,
    input  logic                       reset1,
    input  logic                       prog_we,
    input  logic [$clog2(DEPTH)-1:0]   prog_addr,
    input  logic [6:0]                 prog_cmd,
    input  logic [WIDTH-1:0]           prog_opa,
    input  logic [WIDTH-1:0]           prog_opb,
    input  logic [$clog2(DEPTH):0]     prog_len,
    input  logic                       start,
    input  logic                       stop_on_err,
    input  logic                       cpu_rdy,
    input  logic [2*WIDTH-1:0]         cpu_result,
    input  logic                       cpu_zero,
    input  logic                       cpu_error,
    output logic [6:0]                 cmd_out,
    output logic [WIDTH-1:0]           op_a,
    output logic [WIDTH-1:0]           op_b,
    output logic                       busy,
    output logic                       done,
    output logic                       timeout,
    output logic [$clog2(DEPTH):0]     res_count,
    input  logic [$clog2(DEPTH)-1:0]   res_addr,
    output logic [2*WIDTH+1:0]         res_data
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    state_t            r_state;
    state_t            w_next;
    logic [AW-1:0]     r_pc;
    logic [LW-1:0]     r_len;
    logic [LW-1:0]     r_res_count;
    logic              r_soe;
    logic              r_timeout;

    logic [6:0]        r_cmd_mem [DEPTH];
    logic [WIDTH-1:0]  r_opa_mem [DEPTH];
    logic [WIDTH-1:0]  r_opb_mem [DEPTH];
    logic [2*WIDTH+1:0] r_res_mem [DEPTH];

    logic              w_phase;
    logic              w_expired;
    logic              w_last;
    logic [LW-1:0]     w_len_sat;

    assign w_len_sat = (prog_len > LW'(DEPTH)) ? LW'(DEPTH) : prog_len;
    assign w_last    = ({1'b0, r_pc} == (r_len - 1'b1));
    assign w_phase   = (r_state == ISSUE) || (r_state == WAIT_BUSY) || (r_state == WAIT_DONE);

    // Any state change restarts the count, so each wait phase gets a fresh budget.
    phase_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .i_clk     (clk1),
        .i_rst_n   (reset1),
        .i_clear   (w_next != r_state),
        .i_enable  (w_phase),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk1) begin
        if (!reset1) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (start) w_next = (prog_len == '0) ? DONE : ISSUE;
            ISSUE:     if (cpu_rdy) w_next = WAIT_BUSY;
                       else if (w_expired) w_next = DONE;
            WAIT_BUSY: if (!cpu_rdy) w_next = WAIT_DONE;
                       else if (w_expired) w_next = DONE;
            WAIT_DONE: if (cpu_rdy) w_next = CAPTURE;
                       else if (w_expired) w_next = DONE;
            CAPTURE:   w_next = (w_last || (r_soe && cpu_error)) ? DONE : ISSUE;
            DONE:      w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk1) begin
        if (!reset1) begin
            r_pc        <= '0;
            r_len       <= '0;
            r_soe       <= 1'b0;
            r_timeout   <= 1'b0;
            r_res_count <= '0;
        end else begin
            if (r_state == IDLE && start) begin
                r_pc        <= '0;
                r_len       <= w_len_sat;
                r_soe       <= stop_on_err;
                r_timeout   <= 1'b0;
                r_res_count <= '0;
            end
            if (w_expired && w_next == DONE) begin
                r_timeout <= 1'b1;
            end
            if (r_state == CAPTURE) begin
                r_res_count <= r_res_count + 1'b1;
                if (w_next == ISSUE) begin
                    r_pc <= r_pc + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk1) begin
        if (prog_we && r_state == IDLE) begin
            r_cmd_mem[prog_addr] <= prog_cmd;
            r_opa_mem[prog_addr] <= prog_opa;
            r_opb_mem[prog_addr] <= prog_opb;
        end
        if (r_state == CAPTURE) begin
            r_res_mem[r_pc] <= {cpu_error, cpu_zero, cpu_result};
        end
    end

    always_comb begin
        cmd_out = NOP_CMD;
        op_a    = '0;
        op_b    = '0;
        busy    = 1'b0;
        done    = 1'b0;
        case (r_state)
            ISSUE: begin
                busy = 1'b1;
                op_a = r_opa_mem[r_pc];
                op_b = r_opb_mem[r_pc];
                if (cpu_rdy) cmd_out = r_cmd_mem[r_pc];
            end
            WAIT_BUSY, WAIT_DONE, CAPTURE: begin
                busy = 1'b1;
                op_a = r_opa_mem[r_pc];
                op_b = r_opb_mem[r_pc];
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign timeout   = r_timeout;
    assign res_count = r_res_count;
    assign res_data  = r_res_mem[res_addr];

endmodule
